// File: rtl/prng_sum_gen_pkg.sv
// prng_pkg: shared types and helpers for prng_sum_gen.
// FSM state encoding, output width rule and LFSR zero-seed fixup.
package prng_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Full-precision sum of three sub-WIDTH signed terms.
    function automatic int sum_width(input int width);
        return width + 1;
    endfunction

    // An all-zero LFSR never leaves zero, so map it to 1.
    // Callers zero-extend their slice to 64 bits and cast back.
    function automatic logic [63:0] nz_fix(input logic [63:0] v);
        return (v == 64'd0) ? 64'd1 : v;
    endfunction

endpackage

// File: rtl/prng_sum_gen_lfsr.sv
// lfsr: one combinational Fibonacci LFSR step.
// Shifts toward the MSB and feeds the tap parity into bit 0.
module lfsr #(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Maximal-length taps (1-based bit numbers), up to four per width.
    function automatic logic [WIDTH-1:0] tap_mask(input int w);
        logic [31:0]      t;
        logic [WIDTH-1:0] m;
        int               tp;
        m = '0;
        case (w)
            6:       t = {8'd6,  8'd5,  8'd0,  8'd0};
            7:       t = {8'd7,  8'd6,  8'd0,  8'd0};
            8:       t = {8'd8,  8'd6,  8'd5,  8'd4};
            9:       t = {8'd9,  8'd5,  8'd0,  8'd0};
            10:      t = {8'd10, 8'd7,  8'd0,  8'd0};
            11:      t = {8'd11, 8'd9,  8'd0,  8'd0};
            12:      t = {8'd12, 8'd6,  8'd4,  8'd1};
            13:      t = {8'd13, 8'd4,  8'd3,  8'd1};
            14:      t = {8'd14, 8'd5,  8'd3,  8'd1};
            15:      t = {8'd15, 8'd14, 8'd0,  8'd0};
            16:      t = {8'd16, 8'd15, 8'd13, 8'd4};
            17:      t = {8'd17, 8'd14, 8'd0,  8'd0};
            18:      t = {8'd18, 8'd11, 8'd0,  8'd0};
            19:      t = {8'd19, 8'd6,  8'd2,  8'd1};
            20:      t = {8'd20, 8'd17, 8'd0,  8'd0};
            21:      t = {8'd21, 8'd19, 8'd0,  8'd0};
            22:      t = {8'd22, 8'd21, 8'd0,  8'd0};
            23:      t = {8'd23, 8'd18, 8'd0,  8'd0};
            24:      t = {8'd24, 8'd23, 8'd22, 8'd17};
            25:      t = {8'd25, 8'd22, 8'd0,  8'd0};
            26:      t = {8'd26, 8'd6,  8'd2,  8'd1};
            27:      t = {8'd27, 8'd5,  8'd2,  8'd1};
            28:      t = {8'd28, 8'd25, 8'd0,  8'd0};
            29:      t = {8'd29, 8'd27, 8'd0,  8'd0};
            30:      t = {8'd30, 8'd6,  8'd4,  8'd1};
            31:      t = {8'd31, 8'd28, 8'd0,  8'd0};
            32:      t = {8'd32, 8'd22, 8'd2,  8'd1};
            default: t = {8'd0,  8'd0,  8'd0,  8'd0};
        endcase
        if (t == 32'd0) begin
            // Outside the table: still cycles, not maximal.
            m = (ONE << (w - 1)) | (ONE << (w - 2));
        end else begin
            for (int i = 0; i < 4; i++) begin
                tp = int'(t[i*8 +: 8]);
                if (tp > 0) begin
                    m = m | (ONE << (tp - 1));
                end
            end
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] TAPS = tap_mask(WIDTH);

    assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/prng_sum_gen.sv
// prng_sum_gen: pseudo-Gaussian samples from the sum of three LFSRs.
// Seedable, discards WARMUP advances, streams over valid/ready.
module prng_sum_gen
    import prng_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int WARMUP = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                seed_load,
    input  logic [WIDTH-1:0]                    seed,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic signed [sum_width(WIDTH)-1:0] m_data
);

    localparam int SW = sum_width(WIDTH);
    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CW-1:0] LAST = CW'(WARMUP - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  s0_q, s0_d, s0_nx, seed0;
    logic [WIDTH-2:0]  s1_q, s1_d, s1_nx, seed1;
    logic [WIDTH-3:0]  s2_q, s2_d, s2_nx, seed2;
    logic              valid_q, valid_d;
    logic signed [SW-1:0] data_q, data_d, sum;
    logic              accept;

    lfsr #(.WIDTH(WIDTH))     u_l0 (.cur(s0_q), .nxt(s0_nx));
    lfsr #(.WIDTH(WIDTH - 1)) u_l1 (.cur(s1_q), .nxt(s1_nx));
    lfsr #(.WIDTH(WIDTH - 2)) u_l2 (.cur(s2_q), .nxt(s2_nx));

    assign seed0 = WIDTH'(nz_fix(64'(seed)));
    assign seed1 = (WIDTH-1)'(nz_fix(64'(seed[WIDTH-2:0])));
    assign seed2 = (WIDTH-2)'(nz_fix(64'(seed[WIDTH-3:0])));

    // s0 drops its LSB so all three terms stay near the same scale.
    assign sum = {{2{s0_q[WIDTH-1]}}, s0_q[WIDTH-1:1]}
               + {{2{s1_q[WIDTH-2]}}, s1_q}
               + {{3{s2_q[WIDTH-3]}}, s2_q};

    assign accept  = !valid_q || m_ready;
    assign m_valid = valid_q;
    assign m_data  = data_q;

    // Next-state: seed load wins, then warm-up advance or sample issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (seed_load) begin
            s0_d    = seed0;
            s1_d    = seed1;
            s2_d    = seed2;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = WARM;
        end else begin
            unique case (state_q)
                WARM: begin
                    s0_d = s0_nx;
                    s1_d = s1_nx;
                    s2_d = s2_nx;
                    if (cnt_q == LAST) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        data_d  = sum;
                        valid_d = 1'b1;
                        s0_d    = s0_nx;
                        s1_d    = s1_nx;
                        s2_d    = s2_nx;
                    end
                end
                default: begin
                    state_d = WARM;
                end
            endcase
        end
    end

    // State registers; reset seeds every LFSR with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARM;
            cnt_q   <= '0;
            s0_q    <= WIDTH'(1);
            s1_q    <= (WIDTH-1)'(1);
            s2_q    <= (WIDTH-2)'(1);
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_prng_sum_gen.sv
// tb_prng_sum_gen: randomized stream checks against a sample-level model.
// Model tracks warm-up edges, accepted samples and the expected sum.
module tb_prng_sum_gen;

    typedef longint unsigned u64;

    localparam int WARMUP = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               seed_load;
    logic [17:0]        seed;
    logic               m_valid;
    logic               m_ready;
    logic signed [18:0] m_data;

    prng_sum_gen #(.WIDTH(18), .WARMUP(WARMUP)) dut (
        .clk      (clk),
        .rst      (rst),
        .seed_load(seed_load),
        .seed     (seed),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_xfer = 0;
    int     xfer_q[$];
    int     first100[100];
    int     qa[$];
    int     qb[$];
    u64     m0, m1, m2;
    int     edges;
    bit     rst_flag = 1'b0;
    bit     stats_on = 1'b0;
    longint st_sum = 0;
    int     st_cnt = 0;
    int     st_oor = 0;
    int     b0 = 0;
    int     b1 = 0;
    int     b2 = 0;

    function automatic void chk(input string nm, input longint act,
                                input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // One LFSR advance: shift up, append parity of the tapped bits.
    function automatic u64 step(input u64 x, input int w);
        u64 taps;
        case (w)
            18:      taps = (64'd1 << 17) | (64'd1 << 10);
            17:      taps = (64'd1 << 16) | (64'd1 << 13);
            default: taps = (64'd1 << 15) | (64'd1 << 14)
                          | (64'd1 << 12) | (64'd1 << 3);
        endcase
        return ((x << 1) | u64'($countones(x & taps) % 2))
               & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic int to_s(input u64 v, input int w);
        int iv;
        iv = int'(v);
        return (iv >= (1 << (w - 1))) ? iv - (1 << w) : iv;
    endfunction

    function automatic int smp(input u64 a, input u64 b, input u64 c);
        return to_s(a >> 1, 17) + to_s(b, 17) + to_s(c, 16);
    endfunction

    function automatic void advance();
        m0 = step(m0, 18);
        m1 = step(m1, 17);
        m2 = step(m2, 16);
    endfunction

    function automatic void restart(input u64 sd);
        m0 = ((sd & 64'h3FFFF) == 0) ? 64'd1 : (sd & 64'h3FFFF);
        m1 = ((sd & 64'h1FFFF) == 0) ? 64'd1 : (sd & 64'h1FFFF);
        m2 = ((sd & 64'h0FFFF) == 0) ? 64'd1 : (sd & 64'h0FFFF);
        for (int i = 0; i < WARMUP; i++) begin
            advance();
        end
        edges = 0;
    endfunction

    // Per-cycle check, then roll the model across the coming edge.
    always @(negedge clk) begin
        bit ev;
        int v;
        int a;
        if (rst) begin
            restart(64'd1);
            chk("rst_valid", longint'(m_valid), 0);
            chk("rst_data", longint'(m_data), 0);
        end else begin
            if (rst_flag) begin
                restart(64'd1);
                rst_flag = 1'b0;
            end
            ev = (edges >= WARMUP + 1);
            chk("stream_valid", longint'(m_valid), longint'(ev));
            if (ev) begin
                chk("stream_data", longint'(m_data),
                    longint'(smp(m0, m1, m2)));
            end
            if (m_valid && m_ready) begin
                v = int'(m_data);
                n_xfer++;
                xfer_q.push_back(v);
                if (stats_on) begin
                    if (v < -163840 || v > 163837) begin
                        st_oor++;
                    end
                    st_sum += v;
                    st_cnt++;
                    a = (v < 0) ? -v : v;
                    if (a < 40000) begin
                        b0++;
                    end else if (a < 80000) begin
                        b1++;
                    end else begin
                        b2++;
                    end
                end
            end
            if (seed_load) begin
                restart(u64'(seed));
            end else begin
                if (ev && m_ready) begin
                    advance();
                end
                if (edges < 1000) begin
                    edges++;
                end
            end
        end
    end

    task automatic measure_rise(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_valid && n < 40);
    endtask

    task automatic wait_xfers(input int n, input bit rnd);
        int target;
        int cyc;
        target = n_xfer + n;
        cyc = 0;
        while (n_xfer < target && cyc < n * 4 + 100) begin
            @(posedge clk);
            #2;
            cyc++;
            if (rnd) begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
        end
        n_cmp++;
        if (n_xfer < target) begin
            n_bad++;
            $display("FAIL wait_xfers: got %0d transfers, expected %0d",
                     n_xfer, target);
        end
    endtask

    task automatic load_seed(input logic [17:0] v);
        @(posedge clk);
        #2;
        seed = v;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int chg;
        rst = 1'b1;
        seed_load = 1'b0;
        seed = '0;
        m_ready = 1'b1;

        chk("pin_step18_one", longint'(step(64'd1, 18)), 2);
        chk("pin_step18_msb", longint'(step(64'h20000, 18)), 1);
        chk("pin_step16_one", longint'(step(64'd1, 16)), 2);
        chk("pin_sum_ones", smp(64'd1, 64'd1, 64'd1), 2);
        chk("pin_sum_neg",
            smp(64'h3FFFF, 64'h1FFFF, 64'hFFFF), -3);
        chk("pin_sum_max",
            smp(64'h1FFFF, 64'hFFFF, 64'h7FFF), 163837);
        chk("pin_sum_min",
            smp(64'h20000, 64'h10000, 64'h8000), -163840);

        repeat (3) @(posedge clk);
        #2;
        xfer_q.delete();
        rst = 1'b0;
        measure_rise(n);
        chk("reset_rise_edge", n, WARMUP + 1);
        wait_xfers(100, 1'b0);
        chk("first_len_ok", longint'(xfer_q.size() >= 100), 1);
        for (int i = 0; i < 100; i++) begin
            first100[i] = (i < xfer_q.size()) ? xfer_q[i] : 0;
        end

        @(posedge clk);
        #2;
        m_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #2;
            chk("bp_hold_valid", longint'(m_valid), 1);
            chk("bp_hold_data", longint'(m_data),
                longint'(smp(m0, m1, m2)));
        end
        m_ready = 1'b1;
        wait_xfers(1000, 1'b1);

        m_ready = 1'b1;
        load_seed(18'h0);
        xfer_q.delete();
        wait_xfers(60, 1'b0);
        qa = xfer_q;
        load_seed(18'h1);
        xfer_q.delete();
        wait_xfers(60, 1'b0);
        qb = xfer_q;
        chk("zero_seed_len",
            longint'(qa.size() >= 60 && qb.size() >= 60), 1);
        chg = 0;
        for (int i = 0; i < 60; i++) begin
            if (i < qa.size() && i < qb.size()) begin
                chk("zero_seed_eq_one", qa[i], qb[i]);
                if (i > 0 && qa[i] != qa[i-1]) begin
                    chg++;
                end
            end
        end
        chk("zero_seed_not_stuck", longint'(chg > 30), 1);

        wait_xfers(20, 1'b0);
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("ml_valid_before", longint'(m_valid), 1);
        seed = 18'h2A5A5;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        chk("ml_valid_drop", longint'(m_valid), 0);
        measure_rise(n);
        chk("ml_rise_edge", n, WARMUP + 1);
        m_ready = 1'b1;
        wait_xfers(50, 1'b1);

        m_ready = 1'b1;
        wait_xfers(10, 1'b0);
        load_seed(18'($urandom));
        wait_xfers(100, 1'b1);

        m_ready = 1'b1;
        wait_xfers(30, 1'b1);
        m_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", longint'(m_valid), 0);
        chk("async_rst_data", longint'(m_data), 0);
        #1;
        rst = 1'b0;
        rst_flag = 1'b1;
        xfer_q.delete();
        measure_rise(n);
        chk("async_rise_edge", n, WARMUP + 1);
        wait_xfers(100, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (i < xfer_q.size()) begin
                chk("async_repeat_seq", xfer_q[i], first100[i]);
            end
        end

        xfer_q.delete();
        stats_on = 1'b1;
        wait_xfers(20000, 1'b0);
        stats_on = 1'b0;
        xfer_q.delete();
        chk("stat_count", longint'(st_cnt >= 20000), 1);
        chk("stat_out_of_range", st_oor, 0);
        chk("stat_mean_near_zero",
            longint'(st_sum <= 1500 * longint'(st_cnt)
                  && st_sum >= -1500 * longint'(st_cnt)), 1);
        chk("stat_hist_b0_gt_b1", longint'(b0 > b1), 1);
        chk("stat_hist_b1_gt_b2", longint'(b1 > b2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
